register_file: RTL



---
 rtl/register_file.sv | 58 +++++
 1 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - MIPS register file: two combinational read ports, one clocked write port, r0 reads zero
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 is never stored; the array starts at 1.
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic              wr_en;

  assign wr_en = rst && we && (wa != '0);

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (!rst) begin
        regs_d[i] = '0;
      end else if (wr_en && (wa == ADDR_W'(i))) begin
        regs_d[i] = wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ra1 == ADDR_W'(i)) rd1 = regs_q[i];
      if (ra2 == ADDR_W'(i)) rd2 = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes reset and address 0, so no forwarding there.
    if (wr_en && (ra1 == wa)) rd1 = wd;
    if (wr_en && (ra2 == wa)) rd2 = wd;
`endif
  end

endmodule
